// File: rtl/aux_perf_monitor.sv
// ---------------------------------------------------------------------------
// aux_perf_monitor
//   Bank of NumCh event counters, each CntBit wide, sitting beside the core so
//   board-level logic can observe it. A halt-driven RUN/FROZEN state machine
//   gates counting. Each counter either wraps or saturates on overflow, and
//   sets a sticky overflow flag when it does. A single registered readout port
//   feeds the display mux.
//
//   Optional feature macro: PERF_MON_SNAPSHOT_EN
//     When defined, each channel gets a shadow register. The snap input loads
//     all shadows at once. While frozen, the readout port shows the shadows
//     instead of the live counters.
// ---------------------------------------------------------------------------
module aux_perf_monitor #(
  parameter int NumCh  = 4,
  parameter int CntBit = 32,
  parameter int SelBit = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NumCh-1:0]  inc,
  input  logic              clr,
  input  logic              halt,
  input  logic              resume,
  input  logic              sat_mode,
  input  logic [SelBit-1:0] sel,
  input  logic              snap,
  output logic [CntBit-1:0] data,
  output logic [NumCh-1:0]  ovf,
  output logic              frozen
);

  typedef enum logic {
    StRun    = 1'b0,
    StFrozen = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_stateNext;
  logic              w_countEn;

  logic [CntBit-1:0] r_cnt [NumCh];
  logic [CntBit-1:0] w_cntNext [NumCh];
  logic [NumCh-1:0]  r_ovf;
  logic [NumCh-1:0]  w_ovfNext;
  logic [NumCh-1:0]  w_hit;
  logic [NumCh-1:0]  w_atMax;

  logic [CntBit-1:0] w_liveSel;
  logic [CntBit-1:0] w_readVal;
  logic [CntBit-1:0] r_data;

  // State register for the halt/resume freeze machine
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StRun;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next state: halt always wins, resume only counts once halt has dropped.
  // Counting is gated by the current state, so the cycle in which halt rises
  // still counts.
  always_comb begin
    w_stateNext = r_state;
    w_countEn   = 1'b0;
    case (r_state)
      StRun: begin
        w_countEn = en;
        if (halt) begin
          w_stateNext = StFrozen;
        end
      end
      StFrozen: begin
        if (resume && !halt) begin
          w_stateNext = StRun;
        end
      end
      default: begin
        w_stateNext = StRun;
      end
    endcase
  end

  assign frozen = (r_state == StFrozen);

  // Per-channel increment qualifiers and the all-ones overflow detector
  always_comb begin
    w_hit   = '0;
    w_atMax = '0;
    for (int i = 0; i < NumCh; i++) begin
      w_hit[i]   = w_countEn & inc[i];
      w_atMax[i] = (r_cnt[i] == {CntBit{1'b1}});
    end
  end

  // Next counter values: a plain increment, or wrap/hold at the maximum
  // depending on sat_mode in the current cycle. Overflow flags only accumulate.
  always_comb begin
    w_ovfNext = r_ovf | (w_hit & w_atMax);
    for (int i = 0; i < NumCh; i++) begin
      w_cntNext[i] = r_cnt[i];
      if (w_hit[i]) begin
        if (w_atMax[i]) begin
          if (!sat_mode) begin
            w_cntNext[i] = '0;
          end
        end else begin
          w_cntNext[i] = r_cnt[i] + CntBit'(1);
        end
      end
    end
  end

  // Counter and sticky flag storage; clr overrides any increment that cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= '0;
      for (int i = 0; i < NumCh; i++) begin
        r_cnt[i] <= '0;
      end
    end else if (clr) begin
      r_ovf <= '0;
      for (int i = 0; i < NumCh; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_ovf <= w_ovfNext;
      for (int i = 0; i < NumCh; i++) begin
        r_cnt[i] <= w_cntNext[i];
      end
    end
  end

  assign ovf = r_ovf;

  // Live readout mux; selects outside the channel range read as zero
  always_comb begin
    w_liveSel = '0;
    for (int i = 0; i < NumCh; i++) begin
      if (sel == SelBit'(i)) begin
        w_liveSel = r_cnt[i];
      end
    end
  end

`ifdef PERF_MON_SNAPSHOT_EN
  logic [CntBit-1:0] r_shadow [NumCh];
  logic [CntBit-1:0] w_shadowSel;

  // Shadow bank: captures the pre-increment live values on snap; clr wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NumCh; i++) begin
        r_shadow[i] <= '0;
      end
    end else if (clr) begin
      for (int i = 0; i < NumCh; i++) begin
        r_shadow[i] <= '0;
      end
    end else if (snap) begin
      for (int i = 0; i < NumCh; i++) begin
        r_shadow[i] <= r_cnt[i];
      end
    end
  end

  // Shadow readout mux; a frozen core shows the snapshot instead of live data
  always_comb begin
    w_shadowSel = '0;
    for (int i = 0; i < NumCh; i++) begin
      if (sel == SelBit'(i)) begin
        w_shadowSel = r_shadow[i];
      end
    end
    w_readVal = frozen ? w_shadowSel : w_liveSel;
  end
`else
  logic w_unusedSnap;

  assign w_unusedSnap = snap;
  assign w_readVal    = w_liveSel;
`endif

  // Registered readout port, one cycle behind sel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else begin
      r_data <= w_readVal;
    end
  end

  assign data = r_data;

endmodule

// File: tb/tb_aux_perf_monitor.sv
// ---------------------------------------------------------------------------
// tb_aux_perf_monitor
//   Self-checking bench for aux_perf_monitor with 4 channels of 4-bit counters,
//   so overflow is reachable in a few cycles. A table of vectors covers
//   counting, readout latency, freeze, wrap/saturate and clear. Hand-written
//   sequences cover clear while frozen, asynchronous reset mid-count and, when
//   PERF_MON_SNAPSHOT_EN is defined, the snapshot shadows.
// ---------------------------------------------------------------------------
module tb_aux_perf_monitor;

  localparam int NumCh  = 4;
  localparam int CntBit = 4;
  localparam int SelBit = 4;

`ifdef PERF_MON_SNAPSHOT_EN
  localparam logic [3:0] FrzRead  = 4'd0;
  localparam logic [3:0] FrzReadA = 4'd0;
`else
  localparam logic [3:0] FrzRead  = 4'd3;
  localparam logic [3:0] FrzReadA = 4'd3;
`endif

  logic              clk;
  logic              rst;
  logic              en;
  logic [NumCh-1:0]  inc;
  logic              clr;
  logic              halt;
  logic              resume;
  logic              sat_mode;
  logic [SelBit-1:0] sel;
  logic              snap;
  logic [CntBit-1:0] data;
  logic [NumCh-1:0]  ovf;
  logic              frozen;

  typedef struct {
    logic       en;
    logic [3:0] inc;
    logic       clr;
    logic       halt;
    logic       resume;
    logic       sat;
    logic [3:0] sel;
    logic [3:0] expData;
    logic [3:0] expOvf;
    logic       expFrozen;
  } vec_t;

  typedef struct {
    string      tag;
    logic [3:0] data;
    logic [3:0] ovf;
    logic       frozen;
  } exp_t;

  vec_t vecs[$];
  exp_t sbQ[$];
  int   compared   = 0;
  int   mismatched = 0;

  aux_perf_monitor #(
    .NumCh (NumCh),
    .CntBit(CntBit),
    .SelBit(SelBit)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .inc     (inc),
    .clr     (clr),
    .halt    (halt),
    .resume  (resume),
    .sat_mode(sat_mode),
    .sel     (sel),
    .snap    (snap),
    .data    (data),
    .ovf     (ovf),
    .frozen  (frozen)
  );

  // Free-running board clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic e, input logic [3:0] in, input logic c,
                               input logic h, input logic r, input logic s,
                               input logic [3:0] sl);
    en       = e;
    inc      = in;
    clr      = c;
    halt     = h;
    resume   = r;
    sat_mode = s;
    sel      = sl;
  endtask

  task automatic pushExpect(input string tag, input logic [3:0] d,
                            input logic [3:0] o, input logic f);
    exp_t x;
    x.tag    = tag;
    x.data   = d;
    x.ovf    = o;
    x.frozen = f;
    sbQ.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    exp_t x;
    if (sbQ.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard: got empty queue, want an entry");
    end else begin
      x = sbQ.pop_front();
      compared++;
      if (data !== x.data) begin
        mismatched++;
        $display("[TB] FAIL %s data: got %0d want %0d", x.tag, data, x.data);
      end
      compared++;
      if (ovf !== x.ovf) begin
        mismatched++;
        $display("[TB] FAIL %s ovf: got %b want %b", x.tag, ovf, x.ovf);
      end
      compared++;
      if (frozen !== x.frozen) begin
        mismatched++;
        $display("[TB] FAIL %s frozen: got %b want %b", x.tag, frozen, x.frozen);
      end
    end
  endtask

  task automatic step(input string tag, input logic e, input logic [3:0] in,
                      input logic c, input logic h, input logic r, input logic s,
                      input logic [3:0] sl, input logic [3:0] d,
                      input logic [3:0] o, input logic f);
    applyStimulus(e, in, c, h, r, s, sl);
    pushExpect(tag, d, o, f);
    tick();
    checkOutput();
  endtask

  task automatic addVec(input logic e, input logic [3:0] in, input logic c,
                        input logic h, input logic r, input logic s,
                        input logic [3:0] sl, input logic [3:0] d,
                        input logic [3:0] o, input logic f);
    vec_t v;
    v.en = e; v.inc = in; v.clr = c; v.halt = h; v.resume = r; v.sat = s;
    v.sel = sl; v.expData = d; v.expOvf = o; v.expFrozen = f;
    vecs.push_back(v);
  endtask

  initial begin
    // Channel 0 counts ten strobes; each read shows the pre-edge value
    for (int j = 0; j < 10; j++) addVec(1, 4'b0001, 0, 0, 0, 0, 4'd0, 4'(j), 4'b0000, 0);
    addVec(1, 4'b0000, 0, 0, 0, 0, 4'd0, 4'd10, 4'b0000, 0);
    addVec(1, 4'b0000, 0, 0, 0, 0, 4'd1, 4'd0,  4'b0000, 0);
    addVec(1, 4'b0000, 0, 0, 0, 0, 4'd2, 4'd0,  4'b0000, 0);
    addVec(1, 4'b0000, 0, 0, 0, 0, 4'd3, 4'd0,  4'b0000, 0);
    addVec(1, 4'b0000, 0, 0, 0, 0, 4'd0, 4'd10, 4'b0000, 0);
    addVec(1, 4'b0000, 0, 0, 0, 0, 4'd9, 4'd0,  4'b0000, 0);
    addVec(1, 4'b0000, 0, 0, 0, 0, 4'd0, 4'd10, 4'b0000, 0);
    addVec(1, 4'b0000, 0, 0, 0, 0, 4'd1, 4'd0,  4'b0000, 0);
    // All channels strobing; halt freezes, resume under halt is ignored
    addVec(1, 4'b1111, 0, 0, 0, 0, 4'd1, 4'd0,    4'b0000, 0);
    addVec(1, 4'b1111, 0, 0, 0, 0, 4'd1, 4'd1,    4'b0000, 0);
    addVec(1, 4'b1111, 0, 1, 0, 0, 4'd1, 4'd2,    4'b0000, 1);
    addVec(1, 4'b1111, 0, 0, 0, 0, 4'd1, FrzRead, 4'b0000, 1);
    addVec(1, 4'b1111, 0, 1, 1, 0, 4'd1, FrzRead, 4'b0000, 1);
    addVec(1, 4'b1111, 0, 0, 1, 0, 4'd1, FrzRead, 4'b0000, 0);
    addVec(1, 4'b1111, 0, 0, 0, 0, 4'd1, 4'd3,    4'b0000, 0);
    addVec(1, 4'b0000, 0, 0, 0, 0, 4'd1, 4'd4,    4'b0000, 0);
    // Wrap mode: 17 strobes on channel 2
    addVec(1, 4'b0000, 1, 0, 0, 0, 4'd2, 4'd4, 4'b0000, 0);
    for (int j = 0; j < 16; j++)
      addVec(1, 4'b0100, 0, 0, 0, 0, 4'd2, 4'(j), (j == 15) ? 4'b0100 : 4'b0000, 0);
    addVec(1, 4'b0100, 0, 0, 0, 0, 4'd2, 4'd0, 4'b0100, 0);
    addVec(1, 4'b0000, 0, 0, 0, 0, 4'd2, 4'd1, 4'b0100, 0);
    // Saturate mode: 17 strobes on channel 2
    addVec(1, 4'b0000, 1, 0, 0, 0, 4'd2, 4'd1, 4'b0000, 0);
    for (int j = 0; j < 16; j++)
      addVec(1, 4'b0100, 0, 0, 0, 1, 4'd2, 4'(j), (j == 15) ? 4'b0100 : 4'b0000, 0);
    addVec(1, 4'b0100, 0, 0, 0, 1, 4'd2, 4'd15, 4'b0100, 0);
    addVec(1, 4'b0000, 0, 0, 0, 1, 4'd2, 4'd15, 4'b0100, 0);
    // Channel 0 to 7, then clr together with a strobe
    for (int j = 0; j < 7; j++) addVec(1, 4'b0001, 0, 0, 0, 0, 4'd0, 4'(j), 4'b0100, 0);
    addVec(1, 4'b0001, 1, 0, 0, 0, 4'd0, 4'd7, 4'b0000, 0);
    addVec(1, 4'b0000, 0, 0, 0, 0, 4'd0, 4'd0, 4'b0000, 0);
    addVec(1, 4'b0000, 0, 0, 0, 0, 4'd2, 4'd0, 4'b0000, 0);

    applyStimulus(0, 4'b0000, 0, 0, 0, 0, 4'd0);
    snap = 1'b0;
    rst  = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    pushExpect("reset", 4'd0, 4'b0000, 1'b0);
    checkOutput();

    for (int k = 0; k < vecs.size(); k++) begin
      step($sformatf("vec%0d", k), vecs[k].en, vecs[k].inc, vecs[k].clr, vecs[k].halt,
           vecs[k].resume, vecs[k].sat, vecs[k].sel, vecs[k].expData, vecs[k].expOvf,
           vecs[k].expFrozen);
    end

    // clr while frozen clears counters but leaves the state alone
    for (int j = 0; j < 3; j++) step("frzPre", 1, 4'b1000, 0, 0, 0, 0, 4'd3, 4'(j), 4'b0000, 0);
    step("frzHalt",   1, 4'b0000, 0, 1, 0, 0, 4'd3, 4'd3,     4'b0000, 1);
    step("frzClr",    1, 4'b0000, 1, 0, 0, 0, 4'd3, FrzReadA, 4'b0000, 1);
    step("frzResume", 1, 4'b0000, 0, 0, 1, 0, 4'd3, 4'd0,     4'b0000, 0);
    step("frzAfter",  1, 4'b0000, 0, 0, 0, 0, 4'd3, 4'd0,     4'b0000, 0);

    // Overflow then freeze, then asynchronous reset between edges
    for (int j = 0; j < 16; j++)
      step("rstPre", 1, 4'b0001, 0, 0, 0, 0, 4'd0, 4'(j), (j == 15) ? 4'b0001 : 4'b0000, 0);
    step("rstHalt", 1, 4'b1111, 0, 1, 0, 0, 4'd0, 4'd0, 4'b0001, 1);
    #2;
    rst = 1'b1;
    #1;
    pushExpect("rstAsync", 4'd0, 4'b0000, 1'b0);
    checkOutput();
    tick();
    applyStimulus(1, 4'b0000, 0, 0, 0, 0, 4'd0);
    rst = 1'b0;
    step("rstIdle", 1, 4'b0000, 0, 0, 0, 0, 4'd0, 4'd0, 4'b0000, 0);

`ifdef PERF_MON_SNAPSHOT_EN
    // Shadow captures 5; live counter moves on to 8 while the shadow holds
    for (int j = 0; j < 5; j++) step("snapPre", 1, 4'b0010, 0, 0, 0, 0, 4'd1, 4'(j), 4'b0000, 0);
    snap = 1'b1;
    step("snapLoad", 1, 4'b0000, 0, 0, 0, 0, 4'd1, 4'd5, 4'b0000, 0);
    snap = 1'b0;
    for (int j = 0; j < 3; j++) step("snapMore", 1, 4'b0010, 0, 0, 0, 0, 4'd1, 4'(5 + j), 4'b0000, 0);
    step("snapHalt",   1, 4'b0000, 0, 1, 0, 0, 4'd1, 4'd8, 4'b0000, 1);
    step("snapFrozen", 1, 4'b0000, 0, 0, 0, 0, 4'd1, 4'd5, 4'b0000, 1);
    step("snapResume", 1, 4'b0000, 0, 0, 1, 0, 4'd1, 4'd5, 4'b0000, 0);
    step("snapLive",   1, 4'b0000, 0, 0, 0, 0, 4'd1, 4'd8, 4'b0000, 0);
`endif

    if (sbQ.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard: got %0d leftover entries want 0", sbQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
